// File: rtl/sdram_cmd_arbiter.sv
// SDRAM bus arbiter: refresh timer plus grant FSM over init/refresh/write/read engines.
// Optional grant-hold watchdog (arb_timeout output) is built when SDRAM_ARB_WDOG_EN is defined.
module sdram_cmd_arbiter #(
    parameter int REF_CNT_MAX = 750
`ifdef SDRAM_ARB_WDOG_EN
    ,
    parameter int WDOG_MAX    = 1023
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_dq_oe,
    input  logic [15:0] wr_dq,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        aref_pend,
    output logic        ref_late,
`ifdef SDRAM_ARB_WDOG_EN
    output logic        arb_timeout,
`endif
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic        sdram_dq_oe,
    output logic [15:0] sdram_dq_out
);

    localparam int RCW = $clog2(REF_CNT_MAX);
    localparam logic [RCW-1:0] REF_LAST = RCW'(REF_CNT_MAX - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ} state_t;

    state_t         r_state;
    state_t         w_nxt_state;
    logic [RCW-1:0] r_ref_cnt;
    logic           r_aref_pend;
    logic           r_ref_late;
    logic           r_last_wr;
    logic           r_aref_en;
    logic           r_wr_en;
    logic           r_rd_en;
    logic           w_wrap;
    logic           w_aref_go;

    assign w_wrap    = (r_state != S_INIT) && (r_ref_cnt == REF_LAST);
    assign w_aref_go = (r_state == S_IDLE) && r_aref_pend;

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WCW = $clog2(WDOG_MAX + 1);
    localparam logic [WCW-1:0] WDOG_ARM = WCW'(WDOG_MAX - 2);

    logic [WCW-1:0] r_wdog_cnt;
    logic           r_arb_timeout;
    logic           w_busy;
    logic           w_end_now;

    assign w_busy    = (r_state == S_AREF) || (r_state == S_WRITE) || (r_state == S_READ);
    assign w_end_now = ((r_state == S_AREF)  && aref_end) ||
                       ((r_state == S_WRITE) && wr_end)   ||
                       ((r_state == S_READ)  && rd_end);
    assign arb_timeout = r_arb_timeout;

    // Timeout is armed one cycle early so the pulse lands on the last granted cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wdog_cnt    <= '0;
            r_arb_timeout <= 1'b0;
        end else begin
            r_arb_timeout <= 1'b0;
            if (!w_busy || r_arb_timeout || w_end_now) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
                if (r_wdog_cnt == WDOG_ARM)
                    r_arb_timeout <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_INIT:  if (init_end) w_nxt_state = S_IDLE;
            S_IDLE: begin
                if (r_aref_pend)         w_nxt_state = S_AREF;
                else if (wr_req && rd_req) w_nxt_state = r_last_wr ? S_READ : S_WRITE;
                else if (wr_req)         w_nxt_state = S_WRITE;
                else if (rd_req)         w_nxt_state = S_READ;
            end
            S_AREF:  if (aref_end) w_nxt_state = S_IDLE;
            S_WRITE: if (wr_end)   w_nxt_state = S_IDLE;
            S_READ:  if (rd_end)   w_nxt_state = S_IDLE;
            default: w_nxt_state = S_INIT;
        endcase
`ifdef SDRAM_ARB_WDOG_EN
        if (w_busy && r_arb_timeout) w_nxt_state = S_IDLE;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_INIT;
            r_aref_en   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_last_wr   <= 1'b0;
            r_ref_cnt   <= '0;
            r_aref_pend <= 1'b0;
            r_ref_late  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_aref_en <= (w_nxt_state == S_AREF);
            r_wr_en   <= (w_nxt_state == S_WRITE);
            r_rd_en   <= (w_nxt_state == S_READ);
            if ((r_state == S_IDLE) && ((w_nxt_state == S_WRITE) || (w_nxt_state == S_READ)))
                r_last_wr <= (w_nxt_state == S_WRITE);

            if (r_state != S_INIT)
                r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + 1'b1;
            // A fresh interval elapsing outranks the clear on refresh entry.
            if (w_wrap)
                r_aref_pend <= 1'b1;
            else if (w_aref_go)
                r_aref_pend <= 1'b0;
            r_ref_late <= w_wrap && r_aref_pend;
        end
    end

    assign aref_en   = r_aref_en;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign aref_pend = r_aref_pend;
    assign ref_late  = r_ref_late;

    always_comb begin
        sdram_cmd    = 4'b0111;
        sdram_ba     = 2'b11;
        sdram_addr   = 13'h1fff;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = 16'h0000;
        case (r_state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            S_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_ba     = wr_ba;
                sdram_addr   = wr_addr;
                sdram_dq_oe  = wr_dq_oe;
                sdram_dq_out = wr_dq;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Central scheduler in front of the SDRAM pins inside the frame-buffer controller.
- Owns the auto-refresh interval timer and arbitrates bus ownership between the init, auto-refresh, write-burst and read-burst engines.
- Write and read get round-robin fairness; refresh has top priority.
- Muxes the granted engine's command/bank/address/data onto the SDRAM interface.
- Sits between the sub-engines and the pin-level outputs, in the 100 MHz SDRAM clock domain.

Parameters:
- REF_CNT_MAX, 750, refresh interval in sys_clk cycles (7.5 us at 100 MHz).
- WDOG_MAX, 1023, grant-hold limit in cycles (optional feature only).

Ports:
- sys_clk  in  1  SDRAM controller clock.
- sys_rst_n  in  1  reset.
- init_end  in  1  init engine finished (level).
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}.
- init_ba  in  2  init bank.
- init_addr  in  13  init address.
- aref_end  in  1  refresh engine done pulse.
- aref_cmd  in  4  refresh command.
- aref_addr  in  13  refresh address.
- wr_req  in  1  write engine requests bus (level).
- wr_end  in  1  write burst done pulse.
- wr_cmd  in  4  write command.
- wr_ba  in  2  write bank.
- wr_addr  in  13  write address.
- wr_dq_oe  in  1  write data drive enable.
- wr_dq  in  16  write data.
- rd_req  in  1  read engine requests bus (level).
- rd_end  in  1  read burst done pulse.
- rd_cmd  in  4  read command.
- rd_ba  in  2  read bank.
- rd_addr  in  13  read address.
- aref_en  out  1  grant to refresh engine.
- wr_en  out  1  grant to write engine.
- rd_en  out  1  grant to read engine.
- aref_pend  out  1  refresh due; active engines must close their burst.
- ref_late  out  1  one-cycle pulse: an interval elapsed while a refresh was already pending.
- sdram_cmd  out  4  muxed command.
- sdram_ba  out  2  muxed bank.
- sdram_addr  out  13  muxed address.
- sdram_dq_oe  out  1  DQ tristate enable.
- sdram_dq_out  out  16  DQ drive value.

Behaviour:
- Clocking and reset: single clock sys_clk. Reset sys_rst_n is asynchronous, active-low.
- Reset values: state=INIT; aref_en=wr_en=rd_en=0; aref_pend=0; ref_late=0; refresh counter=0; last_grant=READ, so write wins the first tie.
- Registered FSM states: INIT, IDLE, AREF, WRITE, READ. Grants are registered and equal (state==AREF/WRITE/READ).
- INIT -> IDLE when init_end=1. Any later drop of init_end is ignored.
- IDLE transitions, priority order:
  - aref_pend=1 -> AREF.
  - else wr_req&rd_req -> the one opposite last_grant.
  - else wr_req -> WRITE.
  - else rd_req -> READ.
- Latency: request seen in IDLE at cycle N gives grant high at N+1.
- AREF -> IDLE on aref_end. WRITE -> IDLE on wr_end. READ -> IDLE on rd_end. The grant drops the cycle after the end pulse.
- There is always at least one IDLE cycle between grants; a request coincident with an end pulse is serviced from IDLE.
- last_grant updates on entry to WRITE or READ.
- Refresh counter:
  - Counts only when state!=INIT; wraps at REF_CNT_MAX-1.
  - On wrap, aref_pend is set.
  - aref_pend clears on the cycle AREF is entered.
  - If the wrap coincides with aref_pend already set, pulse ref_late for one cycle and leave aref_pend set.
  - If a wrap coincides with AREF entry, aref_pend stays set: set wins.
- Pin mux (combinational, selected by state):
  - INIT -> init_* signals.
  - AREF -> aref_cmd and aref_addr, with ba=2'b11.
  - WRITE -> wr_*.
  - READ -> rd_*.
  - IDLE -> cmd 4'b0111 (NOP), ba 2'b11, addr 13'h1fff.
- sdram_dq_oe = wr_dq_oe only in WRITE, else 0. sdram_dq_out = wr_dq in WRITE, else 0.
- Reset asserted mid-burst: immediate return to INIT, grants 0, pins at the INIT mux selection. Sub-engines are reset by the same signal.
- end pulses that arrive in a state they do not belong to are ignored.

Optional Feature:
- Macro: SDRAM_ARB_WDOG_EN.
- When defined:
  - A counter runs while in AREF, WRITE or READ and clears in IDLE.
  - On reaching WDOG_MAX, the FSM is forced to IDLE and the grant drops the next cycle.
  - Output arb_timeout (1 bit, reset 0) pulses for one cycle.
  - last_grant is still updated normally.
- When undefined: no counter, no arb_timeout port; a missing end pulse hangs the grant indefinitely.

Test Plan:
- Reset, hold init_end=0 for 200 cycles -> state INIT, sdram_cmd tracks init_cmd, all grants 0. Raise init_end -> IDLE next cycle, sdram_cmd=4'b0111.
- wr_req and rd_req held high together, end pulses 64 cycles after each grant -> grants alternate WRITE, READ, WRITE, READ, with exactly one IDLE cycle between grants.
- After init, no requests -> aref_pend rises at cycle 750. aref_en asserts the next cycle; pulse aref_end 10 cycles later -> aref_pend=0 and aref_en=0 one cycle after.
- WRITE granted, wr_end withheld for 800 cycles, rd_req high -> aref_pend set at wrap. ref_late pulses once at the second wrap (cycle 1500). After wr_end, the next grant is AREF, not READ.
- Assert sys_rst_n=0 mid-READ burst -> rd_en=0 and state INIT asynchronously, before the next clock edge; counter=0.
- With SDRAM_ARB_WDOG_EN and WDOG_MAX=100, grant WRITE and never pulse wr_end -> arb_timeout pulses at cycle 100 of the grant; wr_en=0 the next cycle; a pending rd_req is then granted.
